wormhole_priority_arbiter: RTL and testbench

// - Controls the N-to-1 flit merge stage: each cycle it picks which of N input slots drives the shared output.
// - Picks the highest-priority head/single flit, then locks the output to that input until its tail flit passes (wormhole).
// - Ties are broken round-robin; a saturating age counter per input prevents starvation.
// - Grant is combinational from registered state, so a flit transfers in the same cycle it is granted.

---
 rtl/noc_pkg.sv | 22 ++
 rtl/rr_prio_select.sv | 48 ++++
 rtl/wormhole_priority_arbiter.sv | 133 +++++++++++++
 tb/tb_wormhole_priority_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry and flit-type encodings used by the
// merge-stage arbiter and its selector.
package noc_pkg;

  localparam int FLIT_SIZE  = 32;
  localparam int HEADER_LEN = 2;
  localparam int CMP_POS    = HEADER_LEN;
  localparam int CMP_LEN    = 4;

  typedef enum logic [HEADER_LEN-1:0] {
    BODY_FLIT   = 2'b00,
    HEAD_FLIT   = 2'b01,
    TAIL_FLIT   = 2'b10,
    SINGLE_FLIT = 2'b11
  } flit_type_e;

  // HEAD and SINGLE flits are the only ones that may open arbitration.
  function automatic logic is_hdr(input logic [HEADER_LEN-1:0] t);
    return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational winner selection: a starved candidate first, otherwise the
// highest priority, with both searches running circularly from the rr pointer.
module rr_prio_select #(
  parameter int N       = 8,
  parameter int CMP_LEN = 4
) (
  input  logic [N-1:0]         i_cand,
  input  logic [N*CMP_LEN-1:0] i_prio,
  input  logic [N-1:0]         i_starved,
  input  logic [$clog2(N)-1:0] i_rr_ptr,
  output logic [$clog2(N)-1:0] o_winner,
  output logic                 o_found
);
  localparam int IW = $clog2(N);

  logic [IW-1:0]      w_idx, w_pwin, w_swin;
  logic [CMP_LEN-1:0] w_prio, w_best;
  logic               w_pfound, w_sfound;

  // Strict '>' keeps the earliest index in circular order on priority ties.
  always_comb begin
    w_idx    = '0;
    w_prio   = '0;
    w_best   = '0;
    w_pwin   = '0;
    w_swin   = '0;
    w_pfound = 1'b0;
    w_sfound = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx  = IW'((int'(i_rr_ptr) + k) % N);
      w_prio = i_prio[CMP_LEN*w_idx +: CMP_LEN];
      if (i_cand[w_idx]) begin
        if (!w_pfound || (w_prio > w_best)) begin
          w_pfound = 1'b1;
          w_best   = w_prio;
          w_pwin   = w_idx;
        end
        if (i_starved[w_idx] && !w_sfound) begin
          w_sfound = 1'b1;
          w_swin   = w_idx;
        end
      end
    end
    o_found  = w_pfound;
    o_winner = w_sfound ? w_swin : w_pwin;
  end

endmodule

// File: rtl/wormhole_priority_arbiter.sv
// N-to-1 wormhole merge arbiter: priority + round-robin + anti-starvation ages,
// output locked to one input from HEAD to TAIL. grant_idx is the merge mux select.
module wormhole_priority_arbiter
  import noc_pkg::*;
#(
  parameter int N       = 8,
  parameter int CMP_LEN = 4,
  parameter int AGE_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_valid,
  input  logic [N*HEADER_LEN-1:0] req_type,
  input  logic [N*CMP_LEN-1:0]    req_prio,
  input  logic                    out_ready,
  output logic [N-1:0]            grant,
  output logic [$clog2(N)-1:0]    grant_idx,
  output logic                    grant_vld,
  output logic                    locked,
  output logic                    proto_err
);
  localparam int IW = $clog2(N);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                r_state, w_state_nxt;
  logic [IW-1:0]         r_owner, r_rr_ptr, w_owner_nxt, w_rr_nxt;
  logic [AGE_W-1:0]      r_age [N];
  logic [N-1:0]          w_cand, w_starved;
  logic [IW-1:0]         w_winner;
  logic                  w_found, w_xfer;
  logic [HEADER_LEN-1:0] w_owner_type, w_xfer_type;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N-1) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    w_cand    = '0;
    w_starved = '0;
    for (int i = 0; i < N; i++) begin
      w_cand[i]    = req_valid[i] && is_hdr(req_type[HEADER_LEN*i +: HEADER_LEN]);
      w_starved[i] = (r_age[i] == AGE_MAX);
    end
  end

  assign w_owner_type = req_type[HEADER_LEN*r_owner +: HEADER_LEN];

  rr_prio_select #(.N(N), .CMP_LEN(CMP_LEN)) u_sel (
    .i_cand    (w_cand),
    .i_prio    (req_prio),
    .i_starved (w_starved),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_found   (w_found)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    grant       = '0;
    grant_idx   = '0;
    proto_err   = 1'b0;
    locked      = (r_state == ST_LOCKED);
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          grant[w_winner] = 1'b1;
          grant_idx       = w_winner;
        end else if (|req_valid) begin
          proto_err = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (req_valid[r_owner]) begin
          if (is_hdr(w_owner_type)) begin
            proto_err = 1'b1;
          end else begin
            grant[r_owner] = 1'b1;
            grant_idx      = r_owner;
          end
        end
      end
      default: ;
    endcase
    grant_vld   = |grant;
    w_xfer      = grant_vld && out_ready;
    w_xfer_type = req_type[HEADER_LEN*grant_idx +: HEADER_LEN];
    // A released lock leaves rr_ptr past the owner; arbitration resumes next cycle.
    if (w_xfer) begin
      if (r_state == ST_IDLE) begin
        if (w_xfer_type == HEAD_FLIT) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_winner;
        end else begin
          w_rr_nxt = next_idx(w_winner);
        end
      end else if (w_xfer_type == TAIL_FLIT) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = next_idx(r_owner);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      // Ages freeze under backpressure so a stall never counts as being passed over.
      if (out_ready) begin
        for (int i = 0; i < N; i++) begin
          if (w_xfer && (int'(grant_idx) == i)) begin
            if (is_hdr(w_xfer_type)) r_age[i] <= '0;
          end else if (w_cand[i] && (r_age[i] != AGE_MAX)) begin
            r_age[i] <= r_age[i] + AGE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wormhole_priority_arbiter.sv
// Directed bench for the wormhole arbiter (N=4): expectations are queued as each
// cycle is driven and checked against the combinational outputs mid-cycle.
module tb_wormhole_priority_arbiter;
  import noc_pkg::*;

  localparam int N = 4;

  logic                    clk;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N*HEADER_LEN-1:0] req_type;
  logic [N*4-1:0]          req_prio;
  logic                    out_ready;
  logic [N-1:0]            grant;
  logic [1:0]              grant_idx;
  logic                    grant_vld;
  logic                    locked;
  logic                    proto_err;

  wormhole_priority_arbiter #(.N(N), .CMP_LEN(4), .AGE_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_prio  (req_prio),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .locked    (locked),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         l;
    logic         pe;
  } exp_t;

  exp_t       sb[$];
  string      tq[$];
  int         vecs = 0;
  int         errs = 0;
  logic [N-1:0] v;
  flit_type_e   ty [N];
  logic [3:0]   pr [N];

  task automatic clr();
    v = '0;
    for (int i = 0; i < N; i++) begin
      ty[i] = BODY_FLIT;
      pr[i] = 4'd0;
    end
  endtask

  task automatic put(input int i, input flit_type_e t, input logic [3:0] p);
    v[i]  = 1'b1;
    ty[i] = t;
    pr[i] = p;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_type[HEADER_LEN*i +: HEADER_LEN] = ty[i];
      req_prio[4*i +: 4]                   = pr[i];
    end
    req_valid = v;
  endtask

  task automatic check();
    exp_t       e;
    string      t;
    logic [1:0] ei;
    e  = sb.pop_front();
    t  = tq.pop_front();
    ei = '0;
    for (int i = 0; i < N; i++) if (e.g[i]) ei = 2'(i);
    vecs++;
    assert (grant === e.g) else begin
      errs++; $error("FAIL %s grant: got %b want %b", t, grant, e.g);
    end
    vecs++;
    assert (grant_idx === ei) else begin
      errs++; $error("FAIL %s grant_idx: got %0d want %0d", t, grant_idx, ei);
    end
    vecs++;
    assert (grant_vld === (|e.g)) else begin
      errs++; $error("FAIL %s grant_vld: got %b want %b", t, grant_vld, |e.g);
    end
    vecs++;
    assert (locked === e.l) else begin
      errs++; $error("FAIL %s locked: got %b want %b", t, locked, e.l);
    end
    vecs++;
    assert (proto_err === e.pe) else begin
      errs++; $error("FAIL %s proto_err: got %b want %b", t, proto_err, e.pe);
    end
  endtask

  // One checked clock cycle: queue expectation, drive, sample at negedge.
  task automatic cyc(input string tag, input logic [N-1:0] g, input logic l, input logic pe);
    exp_t e;
    e.g = g; e.l = l; e.pe = pe;
    sb.push_back(e);
    tq.push_back(tag);
    pack();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic run();
    pack();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    run();
    run();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_type  = '0;
    req_prio  = '0;
    clr();
    @(posedge clk); #1;
    do_reset();
    cyc("reset_state", 4'b0000, 1'b0, 1'b0);

    // Reset while a packet owns the output.
    clr(); put(1, HEAD_FLIT, 4'd2);
    cyc("t1_head", 4'b0010, 1'b0, 1'b0);
    clr(); put(1, BODY_FLIT, 4'd0);
    cyc("t1_body", 4'b0010, 1'b1, 1'b0);
    rst = 1'b1;
    run();
    run();
    rst = 1'b0;
    clr();
    cyc("t1_after_rst", 4'b0000, 1'b0, 1'b0);
    clr(); put(2, SINGLE_FLIT, 4'd1);
    cyc("t1_single", 4'b0100, 1'b0, 1'b0);
    clr();
    cyc("t1_idle", 4'b0000, 1'b0, 1'b0);

    // Priority selection and wormhole lock.
    clr(); put(0, HEAD_FLIT, 4'd3); put(2, HEAD_FLIT, 4'd9);
    cyc("t2_prio", 4'b0100, 1'b0, 1'b0);
    clr(); put(0, HEAD_FLIT, 4'd15); put(2, BODY_FLIT, 4'd0);
    cyc("t2_body0", 4'b0100, 1'b1, 1'b0);
    cyc("t2_body1", 4'b0100, 1'b1, 1'b0);
    put(2, TAIL_FLIT, 4'd0);
    cyc("t2_tail", 4'b0100, 1'b1, 1'b0);
    clr(); put(0, HEAD_FLIT, 4'd15);
    cyc("t2_next_head", 4'b0001, 1'b0, 1'b0);
    clr(); put(0, TAIL_FLIT, 4'd0);
    cyc("t2_in0_tail", 4'b0001, 1'b1, 1'b0);

    // Round-robin among equal-priority singles.
    do_reset();
    clr();
    for (int i = 0; i < N; i++) put(i, SINGLE_FLIT, 4'd5);
    cyc("t3_rr0", 4'b0001, 1'b0, 1'b0);
    cyc("t3_rr1", 4'b0010, 1'b0, 1'b0);
    cyc("t3_rr2", 4'b0100, 1'b0, 1'b0);
    cyc("t3_rr3", 4'b1000, 1'b0, 1'b0);
    cyc("t3_rr4", 4'b0001, 1'b0, 1'b0);
    cyc("t3_rr5", 4'b0010, 1'b0, 1'b0);

    // Backpressure mid-packet: a waiting single must not age while stalled.
    clr(); put(0, HEAD_FLIT, 4'd1);
    cyc("t4_head", 4'b0001, 1'b0, 1'b0);
    clr(); put(0, BODY_FLIT, 4'd0);
    cyc("t4_body", 4'b0001, 1'b1, 1'b0);
    out_ready = 1'b0;
    put(3, SINGLE_FLIT, 4'd5);
    for (int k = 0; k < 5; k++) cyc("t4_stall", 4'b0001, 1'b1, 1'b0);
    out_ready = 1'b1;
    clr(); put(0, BODY_FLIT, 4'd0);
    cyc("t4_resume", 4'b0001, 1'b1, 1'b0);
    put(0, TAIL_FLIT, 4'd0);
    cyc("t4_tail", 4'b0001, 1'b1, 1'b0);
    clr(); put(1, SINGLE_FLIT, 4'd5); put(3, SINGLE_FLIT, 4'd5);
    cyc("t4_rr_kept", 4'b0010, 1'b0, 1'b0);
    clr(); put(3, SINGLE_FLIT, 4'd5);
    cyc("t4_in3", 4'b1000, 1'b0, 1'b0);

    // Starvation: low-priority input wins once its age saturates.
    do_reset();
    clr(); put(1, SINGLE_FLIT, 4'd1); put(3, SINGLE_FLIT, 4'd15);
    for (int k = 0; k < 7; k++) cyc("t5_high", 4'b1000, 1'b0, 1'b0);
    cyc("t5_starved", 4'b0010, 1'b0, 1'b0);
    cyc("t5_age_clr", 4'b1000, 1'b0, 1'b0);

    // Protocol errors, locked and idle.
    do_reset();
    clr(); put(1, HEAD_FLIT, 4'd4);
    cyc("t6_head", 4'b0010, 1'b0, 1'b0);
    clr(); put(1, BODY_FLIT, 4'd0);
    cyc("t6_body", 4'b0010, 1'b1, 1'b0);
    clr(); put(1, HEAD_FLIT, 4'd4); put(0, SINGLE_FLIT, 4'd15);
    cyc("t6_perr", 4'b0000, 1'b1, 1'b1);
    clr(); put(1, BODY_FLIT, 4'd0);
    cyc("t6_perr_gone", 4'b0010, 1'b1, 1'b0);
    put(1, TAIL_FLIT, 4'd0);
    cyc("t6_tail", 4'b0010, 1'b1, 1'b0);
    clr(); put(0, SINGLE_FLIT, 4'd2);
    cyc("t6_unlocked", 4'b0001, 1'b0, 1'b0);
    clr(); put(2, BODY_FLIT, 4'd0);
    cyc("t6_idle_perr", 4'b0000, 1'b0, 1'b1);
    clr();
    cyc("t6_quiet", 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
